timer_avmm_master: RTL and testbench

- Avalon-MM initiator that programs and services the SoC interval timer's 16-bit register map on behalf of fabric logic with no CPU in the path (e.g. a CRC accelerator that needs a hardware timeout).
- Accepts high-level commands (start, stop, snapshot, ack), sequences the required register writes and reads, and returns snapshot values.
- Converts the timer irq into a single-cycle event pulse.

---
 rtl/timer_avmm_pkg.sv | 58 +++++
 rtl/timer_avmm_master_xfer.sv | 106 ++++++++++
 rtl/timer_avmm_master.sv | 237 +++++++++++++++++++++++
 tb/tb_timer_avmm_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_avmm_pkg.sv
// ----------------------------------------------------------------------------
// timer_avmm_pkg
// Shared definitions for the interval-timer Avalon-MM master:
//   - word addresses of the timer's 16-bit register map
//   - control register bit positions
//   - command opcode encoding seen on cmd_op
//   - sequencing FSM state encoding
//   - helper that assembles a control register word
// Optional build macro used by the top level: TIMER_MASTER_AUTOACK_EN
// ----------------------------------------------------------------------------
package timer_avmm_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [1:0] {
    OP_START    = 2'd0,
    OP_STOP     = 2'd1,
    OP_SNAPSHOT = 2'd2,
    OP_ACK      = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTL,
    WR_STOP,
    WR_SNAP,
    RD_SL,
    RD_SH,
    WAIT_RD,
    WR_ACK,
    DONE
  } state_e;

  // Control word with all reserved upper bits forced to zero.
  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/timer_avmm_master_xfer.sv
// ----------------------------------------------------------------------------
// avmm_single_xfer
// Issues one Avalon-MM read or write at a time. All av_* outputs are flops,
// so they stay frozen while the slave holds waitrequest.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   xfer_start          launch a transfer (only when no transfer is in flight)
//   xfer_write          1 = write, 0 = read
//   xfer_addr/wdata     word address and write data for the transfer
//   xfer_accept         cycle in which the slave takes the request
//   xfer_done           write accepted, or read data valid this cycle
//   xfer_rdata          read data, valid while xfer_done for a read
//   av_*                Avalon-MM initiator signals
// ----------------------------------------------------------------------------
module avmm_single_xfer #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        xfer_start,
  input  logic        xfer_write,
  input  logic [2:0]  xfer_addr,
  input  logic [15:0] xfer_wdata,
  output logic        xfer_accept,
  output logic        xfer_done,
  output logic [15:0] xfer_rdata,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        av_waitrequest
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_pend_q, rd_pend_d;
  logic [2:0]  cnt_q, cnt_d;

  assign xfer_accept   = cs_q && !av_waitrequest;
  // cnt counts down the read latency; data is on the bus when it reaches 1.
  assign xfer_done     = (xfer_accept && !wn_q) || (rd_pend_q && (cnt_q == 3'd1));
  assign xfer_rdata    = av_readdata;

  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_address    = addr_q;
  assign av_writedata  = wdata_q;

  always_comb begin
    cs_d      = cs_q;
    wn_d      = wn_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_pend_d = rd_pend_q;
    cnt_d     = cnt_q;

    // Bus returns to its idle values once the slave takes the request.
    if (xfer_accept) begin
      cs_d    = 1'b0;
      wn_d    = 1'b1;
      addr_d  = '0;
      wdata_d = '0;
      if (wn_q) begin
        rd_pend_d = 1'b1;
        cnt_d     = LAT;
      end
    end

    if (rd_pend_q) begin
      if (cnt_q == 3'd1) rd_pend_d = 1'b0;
      else               cnt_d     = cnt_q - 3'd1;
    end

    // A new request may be launched in the same cycle the previous one ends.
    if (xfer_start) begin
      cs_d    = 1'b1;
      wn_d    = !xfer_write;
      addr_d  = xfer_addr;
      wdata_d = xfer_write ? xfer_wdata : 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_pend_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_pend_q <= rd_pend_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_avmm_master.sv
// ----------------------------------------------------------------------------
// timer_avmm_master
// Avalon-MM initiator that programs the SoC interval timer on behalf of
// fabric logic. Commands (START/STOP/SNAPSHOT/ACK) are expanded into the
// register write/read sequences; SNAPSHOT returns the 32-bit counter value.
// The timer irq is turned into a one-cycle timeout_evt pulse.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op         command handshake and opcode
//   cmd_period, cmd_irq_en             START operands
//   rsp_valid, rsp_data                completion pulse and snapshot value
//   timeout_evt                        irq rising-edge pulse
//   av_*                               Avalon-MM initiator to the timer
//   irq                                timer interrupt
// Build option: define TIMER_MASTER_AUTOACK_EN to clear the timeout flag
// automatically (internal status write) whenever the timer fires.
// ----------------------------------------------------------------------------
module timer_avmm_master
  import timer_avmm_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter bit CONT_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_irq_en,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        timeout_evt,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        av_waitrequest,
  input  logic        irq
);

  state_e      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] snap_q, snap_d;
  logic        rd_hi_q, rd_hi_d;
  logic        irq_q;

  logic        xfer_start, xfer_write, xfer_accept, xfer_done;
  logic [2:0]  xfer_addr;
  logic [15:0] xfer_wdata, xfer_rdata;

  assign timeout_evt = irq && !irq_q;

`ifdef TIMER_MASTER_AUTOACK_EN
  // auto_q marks an internally generated ACK so DONE (and rsp_valid) is skipped.
  logic auto_q, auto_d;
  logic pend_q, pend_d;
  logic auto_fire;
  assign auto_fire = (state_q == IDLE) && (timeout_evt || pend_q);
  assign cmd_ready = (state_q == IDLE) && !auto_fire;
`else
  assign cmd_ready = (state_q == IDLE);
`endif

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_valid ? snap_q : 32'h0;

  avmm_single_xfer #(.READ_LATENCY(READ_LATENCY)) u_xfer (
    .clk            (clk),
    .reset_n        (reset_n),
    .xfer_start     (xfer_start),
    .xfer_write     (xfer_write),
    .xfer_addr      (xfer_addr),
    .xfer_wdata     (xfer_wdata),
    .xfer_accept    (xfer_accept),
    .xfer_done      (xfer_done),
    .xfer_rdata     (xfer_rdata),
    .av_address     (av_address),
    .av_chipselect  (av_chipselect),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest)
  );

  // Each transition into a bus state launches that state's transfer in the
  // same cycle, so back-to-back register accesses have no idle gap.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    irq_en_d   = irq_en_q;
    snap_d     = snap_q;
    rd_hi_d    = rd_hi_q;
    xfer_start = 1'b0;
    xfer_write = 1'b1;
    xfer_addr  = ADDR_STATUS;
    xfer_wdata = 16'h0000;
`ifdef TIMER_MASTER_AUTOACK_EN
    auto_d = auto_q;
    pend_d = pend_q || (timeout_evt && (state_q != IDLE));
`endif

    case (state_q)
      IDLE: begin
`ifdef TIMER_MASTER_AUTOACK_EN
        if (auto_fire) begin
          state_d    = WR_ACK;
          auto_d     = 1'b1;
          pend_d     = 1'b0;
          xfer_start = 1'b1;
          xfer_addr  = ADDR_STATUS;
        end else
`endif
        if (cmd_valid) begin
          period_d = cmd_period;
          irq_en_d = cmd_irq_en;
          snap_d   = '0;
`ifdef TIMER_MASTER_AUTOACK_EN
          auto_d   = 1'b0;
`endif
          xfer_start = 1'b1;
          case (cmd_op_e'(cmd_op))
            OP_START: begin
              state_d    = WR_PL;
              xfer_addr  = ADDR_PERIODL;
              xfer_wdata = cmd_period[15:0];
            end
            OP_STOP: begin
              state_d    = WR_STOP;
              xfer_addr  = ADDR_CONTROL;
              xfer_wdata = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
            end
            OP_SNAPSHOT: begin
              state_d   = WR_SNAP;
              xfer_addr = ADDR_SNAPL;
            end
            default: begin
              state_d   = WR_ACK;
              xfer_addr = ADDR_STATUS;
            end
          endcase
        end
      end

      WR_PL: if (xfer_done) begin
        state_d    = WR_PH;
        xfer_start = 1'b1;
        xfer_addr  = ADDR_PERIODH;
        xfer_wdata = period_q[31:16];
      end

      WR_PH: if (xfer_done) begin
        state_d    = WR_CTL;
        xfer_start = 1'b1;
        xfer_addr  = ADDR_CONTROL;
        xfer_wdata = ctrl_word(irq_en_q, CONT_DEFAULT, 1'b1, 1'b0);
      end

      WR_CTL, WR_STOP: if (xfer_done) state_d = DONE;

      WR_SNAP: if (xfer_done) begin
        state_d    = RD_SL;
        xfer_start = 1'b1;
        xfer_write = 1'b0;
        xfer_addr  = ADDR_SNAPL;
      end

      RD_SL: if (xfer_accept) begin
        state_d = WAIT_RD;
        rd_hi_d = 1'b0;
      end

      RD_SH: if (xfer_accept) begin
        state_d = WAIT_RD;
        rd_hi_d = 1'b1;
      end

      WAIT_RD: if (xfer_done) begin
        if (!rd_hi_q) begin
          snap_d[15:0] = xfer_rdata;
          state_d      = RD_SH;
          xfer_start   = 1'b1;
          xfer_write   = 1'b0;
          xfer_addr    = ADDR_SNAPH;
        end else begin
          snap_d[31:16] = xfer_rdata;
          state_d       = DONE;
        end
      end

      WR_ACK: if (xfer_done) begin
`ifdef TIMER_MASTER_AUTOACK_EN
        state_d = auto_q ? IDLE : DONE;
        auto_d  = 1'b0;
`else
        state_d = DONE;
`endif
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      irq_en_q <= 1'b0;
      snap_q   <= '0;
      rd_hi_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      irq_en_q <= irq_en_d;
      snap_q   <= snap_d;
      rd_hi_q  <= rd_hi_d;
      irq_q    <= irq;
    end
  end

`ifdef TIMER_MASTER_AUTOACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      auto_q <= auto_d;
      pend_q <= pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_timer_avmm_master.sv
// ----------------------------------------------------------------------------
// tb_timer_avmm_master
// Directed bench for timer_avmm_master (READ_LATENCY=2, CONT_DEFAULT=1).
// A small slave model answers snapshot reads; a monitor logs every accepted
// bus transfer as {write, address, writedata}.
// ----------------------------------------------------------------------------
module tb_timer_avmm_master;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_irq_en;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        timeout_evt;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_waitrequest;
  logic        irq;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int evt_cnt   = 0;
  int rsp_cnt   = 0;
  logic [19:0] log_q[$];

  logic       s1_v, s2_v;
  logic [2:0] s1_a, s2_a;

  timer_avmm_master #(.READ_LATENCY(2), .CONT_DEFAULT(1'b1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_period     (cmd_period),
    .cmd_irq_en     (cmd_irq_en),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .timeout_evt    (timeout_evt),
    .av_address     (av_address),
    .av_chipselect  (av_chipselect),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave returns read data two cycles after it accepts the read.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_a <= '0; s2_a <= '0;
    end else begin
      s1_v <= av_chipselect && av_write_n && !av_waitrequest;
      s1_a <= av_address;
      s2_v <= s1_v;
      s2_a <= s1_a;
    end
  end
  assign av_readdata = !s2_v ? 16'h0000 :
                       (s2_a == 3'd4) ? 16'h1234 :
                       (s2_a == 3'd5) ? 16'h0ABC : 16'hDEAD;

  always @(posedge clk) begin
    if (reset_n && av_chipselect && !av_waitrequest)
      log_q.push_back({!av_write_n, av_address, av_writedata});
    if (reset_n && timeout_evt) evt_cnt <= evt_cnt + 1;
    if (reset_n && rsp_valid)   rsp_cnt <= rsp_cnt + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [19:0] xfer(input logic we, input logic [2:0] a, input logic [15:0] d);
    return {we, a, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expectXfer(input string tag, input int base, input int idx, input logic [19:0] exp);
    logic [19:0] obs;
    obs = (base + idx < log_q.size()) ? log_q[base + idx] : 20'hFFFFF;
    checkOutput(tag, 32'(obs), 32'(exp));
  endtask

  // Presents a command for one cycle; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] period, input logic en);
    cmd_op     = op;
    cmd_period = period;
    cmd_irq_en = en;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic waitRsp(input string tag, input int start_n, input int exp_n);
    int n;
    n = start_n;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int base;
    int ebase;
    int rbase;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = '0;
    cmd_irq_en = 1'b0; av_waitrequest = 1'b0; irq = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_evt", 32'(timeout_evt), 32'd0);
    checkOutput("rst_cs", 32'(av_chipselect), 32'd0);
    checkOutput("rst_write_n", 32'(av_write_n), 32'd1);
    checkOutput("rst_addr", 32'(av_address), 32'd0);
    checkOutput("rst_wdata", 32'(av_writedata), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] START zero-wait");
    base = log_q.size();
    applyStimulus(2'd0, 32'h0001_86A0, 1'b1);
    checkOutput("start_c1_cs", 32'(av_chipselect), 32'd1);
    checkOutput("start_c1_addr", 32'(av_address), 32'd2);
    checkOutput("start_c1_wdata", 32'(av_writedata), 32'h86A0);
    checkOutput("start_c1_write_n", 32'(av_write_n), 32'd0);
    checkOutput("start_c1_ready", 32'(cmd_ready), 32'd0);
    waitRsp("start_latency", 1, 4);
    checkOutput("start_rsp_data", rsp_data, 32'd0);
    expectXfer("start_wr0", base, 0, xfer(1'b1, 3'd2, 16'h86A0));
    expectXfer("start_wr1", base, 1, xfer(1'b1, 3'd3, 16'h0001));
    expectXfer("start_wr2", base, 2, xfer(1'b1, 3'd1, 16'h0007));
    checkOutput("start_nxfers", 32'(log_q.size() - base), 32'd3);
    @(negedge clk);
    checkOutput("start_rsp_pulse", 32'(rsp_valid), 32'd0);
    checkOutput("start_ready_back", 32'(cmd_ready), 32'd1);

    $display("[TB] START with waitrequest on period_h");
    base = log_q.size();
    applyStimulus(2'd0, 32'h0001_86A0, 1'b1);
    @(negedge clk);
    checkOutput("ws_ph_addr", 32'(av_address), 32'd3);
    av_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ws_hold_addr", 32'(av_address), 32'd3);
      checkOutput("ws_hold_data", 32'(av_writedata), 32'h0001);
      checkOutput("ws_hold_cs", 32'(av_chipselect & ~av_write_n), 32'd1);
    end
    av_waitrequest = 1'b0;
    waitRsp("ws_latency", 5, 7);
    checkOutput("ws_nxfers", 32'(log_q.size() - base), 32'd3);
    expectXfer("ws_wr2", base, 2, xfer(1'b1, 3'd1, 16'h0007));
    @(negedge clk);

    $display("[TB] SNAPSHOT");
    base = log_q.size();
    applyStimulus(2'd2, 32'h0, 1'b0);
    waitRsp("snap_latency", 1, 8);
    checkOutput("snap_rsp_data", rsp_data, 32'h0ABC_1234);
    expectXfer("snap_wr", base, 0, xfer(1'b1, 3'd4, 16'h0000));
    expectXfer("snap_rdl", base, 1, xfer(1'b0, 3'd4, 16'h0000));
    expectXfer("snap_rdh", base, 2, xfer(1'b0, 3'd5, 16'h0000));
    @(negedge clk);
    checkOutput("snap_data_cleared", rsp_data, 32'd0);

    $display("[TB] STOP and ACK");
    base = log_q.size();
    applyStimulus(2'd1, 32'h0, 1'b0);
    waitRsp("stop_latency", 1, 2);
    expectXfer("stop_wr", base, 0, xfer(1'b1, 3'd1, 16'h0008));
    @(negedge clk);
    applyStimulus(2'd3, 32'h0, 1'b0);
    waitRsp("ack_latency", 1, 2);
    expectXfer("ack_wr", base, 1, xfer(1'b1, 3'd0, 16'h0000));
    @(negedge clk);

    $display("[TB] irq edge");
    base  = log_q.size();
    ebase = evt_cnt;
    rbase = rsp_cnt;
    irq = 1'b1;
    #1;
    checkOutput("irq_evt_rise", 32'(timeout_evt), 32'd1);
    @(negedge clk);
    checkOutput("irq_evt_single", 32'(timeout_evt), 32'd0);
    repeat (9) @(negedge clk);
    checkOutput("irq_evt_count", 32'(evt_cnt - ebase), 32'd1);
    checkOutput("irq_no_rsp", 32'(rsp_cnt - rbase), 32'd0);
`ifdef TIMER_MASTER_AUTOACK_EN
    checkOutput("irq_autoack_n", 32'(log_q.size() - base), 32'd1);
    expectXfer("irq_autoack_wr", base, 0, xfer(1'b1, 3'd0, 16'h0000));
`else
    checkOutput("irq_no_xfer", 32'(log_q.size() - base), 32'd0);
`endif
    irq = 1'b0;
    @(negedge clk);

    $display("[TB] cmd_valid held across START");
    base  = log_q.size();
    rbase = rsp_cnt;
    cmd_op = 2'd0; cmd_period = 32'h0000_0010; cmd_irq_en = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("busy_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    checkOutput("busy_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("busy_2nd_addr", 32'(av_address), 32'd2);
    waitRsp("busy_2nd_latency", 1, 4);
    checkOutput("busy_rsp_count", 32'(rsp_cnt - rbase), 32'd1);
    expectXfer("busy_ctl0", base, 2, xfer(1'b1, 3'd1, 16'h0006));
    expectXfer("busy_ctl1", base, 5, xfer(1'b1, 3'd1, 16'h0006));
    @(negedge clk);

    $display("[TB] reset during period_h write");
    applyStimulus(2'd0, 32'hABCD_1234, 1'b0);
    @(negedge clk);
    checkOutput("mid_ph_addr", 32'(av_address), 32'd3);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_cs", 32'(av_chipselect), 32'd0);
    checkOutput("mid_rst_write_n", 32'(av_write_n), 32'd1);
    checkOutput("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    base = log_q.size();
    applyStimulus(2'd0, 32'h0000_0005, 1'b1);
    waitRsp("post_rst_latency", 1, 4);
    expectXfer("post_rst_wr0", base, 0, xfer(1'b1, 3'd2, 16'h0005));
    expectXfer("post_rst_wr1", base, 1, xfer(1'b1, 3'd3, 16'h0000));
    expectXfer("post_rst_wr2", base, 2, xfer(1'b1, 3'd1, 16'h0007));
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
